// File: rtl/fetch_queue.sv
// Two-wide instruction fetch queue between fetch and decode, with flush/redirect and stall.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = `ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ext_flush,
  input  logic                   fb_redirect,
  input  logic                   ext_stall,
  input  logic [1:0]             in_valid,
  input  logic [1:0][31:0]       in_instr,
  input  logic [1:0][ADDR_W-1:0] in_pc,
  input  logic [1:0]             in_guesses_branch,
  input  logic [1:0]             in_prediction,
  output logic                   o_ready,
  output logic [1:0]             out_valid,
  output logic [1:0][31:0]       out_instr,
  output logic [1:0][ADDR_W-1:0] out_pc,
  output logic [1:0]             out_guesses_branch,
  output logic [1:0]             out_prediction
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic              mem_gb    [DEPTH];
  logic              mem_pr    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_nx1;
  logic [PW-1:0] tail_nx1;
  logic [CW-1:0] count;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;
  logic          flush;
  logic          push_en;
  logic          first_slot;

  assign flush    = ext_flush | fb_redirect;
  assign head_nx1 = head + PW'(1);
  assign tail_nx1 = tail + PW'(1);

  // Readiness looks only at the registered count, so a full group always fits.
  assign o_ready = (CW'(DEPTH) - count) >= CW'(2);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass  = reset && (count == '0) && !ext_stall && !flush;
  assign push_en = reset && o_ready && (|in_valid) && !flush && !bypass;
`else
  assign push_en = reset && o_ready && (|in_valid) && !flush;
`endif

  // A lone slot-1 fetch is compacted into a single entry at the tail.
  assign first_slot = ~in_valid[0];

  always_comb begin
    push_cnt = '0;
    if (push_en) push_cnt = (&in_valid) ? CW'(2) : CW'(1);
  end

  always_comb begin
    pop_cnt = '0;
    if (!ext_stall) pop_cnt = (count >= CW'(2)) ? CW'(2) : count;
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_instr[tail] <= in_instr[first_slot];
      mem_pc[tail]    <= in_pc[first_slot];
      mem_gb[tail]    <= in_guesses_branch[first_slot];
      mem_pr[tail]    <= in_prediction[first_slot];
      if (&in_valid) begin
        mem_instr[tail_nx1] <= in_instr[1];
        mem_pc[tail_nx1]    <= in_pc[1];
        mem_gb[tail_nx1]    <= in_guesses_branch[1];
        mem_pr[tail_nx1]    <= in_prediction[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push_cnt);
      count <= count + push_cnt - pop_cnt;
    end
  end

  always_comb begin
    out_valid          = '0;
    out_instr          = '0;
    out_pc             = '0;
    out_guesses_branch = '0;
    out_prediction     = '0;
    if (count >= CW'(1)) begin
      out_valid[0]          = 1'b1;
      out_instr[0]          = mem_instr[head];
      out_pc[0]             = mem_pc[head];
      out_guesses_branch[0] = mem_gb[head];
      out_prediction[0]     = mem_pr[head];
    end
    if (count >= CW'(2)) begin
      out_valid[1]          = 1'b1;
      out_instr[1]          = mem_instr[head_nx1];
      out_pc[1]             = mem_pc[head_nx1];
      out_guesses_branch[1] = mem_gb[head_nx1];
      out_prediction[1]     = mem_pr[head_nx1];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: incoming group goes straight to decode, compacted the same way.
    if (bypass && (|in_valid)) begin
      out_valid[0]          = 1'b1;
      out_instr[0]          = in_instr[first_slot];
      out_pc[0]             = in_pc[first_slot];
      out_guesses_branch[0] = in_guesses_branch[first_slot];
      out_prediction[0]     = in_prediction[first_slot];
      if (&in_valid) begin
        out_valid[1]          = 1'b1;
        out_instr[1]          = in_instr[1];
        out_pc[1]             = in_pc[1];
        out_guesses_branch[1] = in_guesses_branch[1];
        out_prediction[1]     = in_prediction[1];
      end
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a negedge scoreboard
// that tracks every accepted entry and checks decode-side order, validity and readiness.
module tb_fetch_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        gb;
    logic        pr;
  } entry_t;

  logic                   clk;
  logic                   reset;
  logic                   ext_flush;
  logic                   fb_redirect;
  logic                   ext_stall;
  logic [1:0]             in_valid;
  logic [1:0][31:0]       in_instr;
  logic [1:0][ADDR_W-1:0] in_pc;
  logic [1:0]             in_guesses_branch;
  logic [1:0]             in_prediction;
  logic                   o_ready;
  logic [1:0]             out_valid;
  logic [1:0][31:0]       out_instr;
  logic [1:0][ADDR_W-1:0] out_pc;
  logic [1:0]             out_guesses_branch;
  logic [1:0]             out_prediction;

  int     n_checks  = 0;
  int     n_fail    = 0;
  int     pop_total = 0;
  bit     mon_en    = 0;
  entry_t exp_q[$];

  int         sz;
  bit         m_ready;
  bit         taken;
  logic [1:0] exp_v;
  entry_t     e;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .ext_flush(ext_flush),
    .fb_redirect(fb_redirect),
    .ext_stall(ext_stall),
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_pc(in_pc),
    .in_guesses_branch(in_guesses_branch),
    .in_prediction(in_prediction),
    .o_ready(o_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_guesses_branch(out_guesses_branch),
    .out_prediction(out_prediction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_group(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    in_valid = v;
    in_pc[0] = p0;
    in_pc[1] = p1;
    in_instr[0] = {16'hC0DE, p0[15:0]};
    in_instr[1] = {16'hC0DE, p1[15:0]};
    in_guesses_branch[0] = p0[2] ^ p0[4];
    in_guesses_branch[1] = p1[2] ^ p1[4];
    in_prediction[0] = p0[3];
    in_prediction[1] = p1[3];
  endtask

  task automatic idle();
    drive_group(2'b00, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_group();
    entry_t t;
    for (int s = 0; s < 2; s++) begin
      if (in_valid[s]) begin
        t.pc = in_pc[s];
        t.instr = in_instr[s];
        t.gb = in_guesses_branch[s];
        t.pr = in_prediction[s];
        exp_q.push_back(t);
      end
    end
  endtask

  // Scoreboard: compare what decode sees against the model, then retire and accept.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!reset || ext_flush || fb_redirect) begin
        exp_q.delete();
      end else begin
        sz = exp_q.size();
        m_ready = (DEPTH - sz) >= 2;
        n_checks++;
        if (o_ready !== m_ready) begin
          n_fail++;
          $display("[TB] FAIL sb_ready: got %b expected %b (model count %0d)", o_ready, m_ready, sz);
        end
        taken = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (sz == 0 && !ext_stall && in_valid != 2'b00) begin
          push_group();
          taken = 1;
        end
`endif
        exp_v = {exp_q.size() >= 2, exp_q.size() >= 1};
        n_checks++;
        if (out_valid !== exp_v) begin
          n_fail++;
          $display("[TB] FAIL sb_valid: got %b expected %b", out_valid, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
          if (exp_v[i]) begin
            e = exp_q[i];
            n_checks++;
            if ({out_pc[i], out_instr[i], out_guesses_branch[i], out_prediction[i]} !==
                {e.pc, e.instr, e.gb, e.pr}) begin
              n_fail++;
              $display("[TB] FAIL sb_slot%0d: got pc=%h instr=%h gb=%b pr=%b expected pc=%h instr=%h gb=%b pr=%b",
                       i, out_pc[i], out_instr[i], out_guesses_branch[i], out_prediction[i],
                       e.pc, e.instr, e.gb, e.pr);
            end
          end else begin
            n_checks++;
            if ({out_pc[i], out_instr[i], out_guesses_branch[i], out_prediction[i]} !== 66'h0) begin
              n_fail++;
              $display("[TB] FAIL sb_zero%0d: got pc=%h instr=%h expected zero", i, out_pc[i], out_instr[i]);
            end
          end
        end
        if (!ext_stall) begin
          for (int i = 0; i < 2; i++) begin
            if (exp_v[i]) begin
              void'(exp_q.pop_front());
              pop_total++;
            end
          end
        end
        if (!taken && m_ready && in_valid != 2'b00) push_group();
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", o_ready); end
    n_checks++;
    if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 00", out_valid); end
    n_checks++;
    if (out_pc !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 0", out_pc); end
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_release: got %b expected 00", out_valid); end
  endtask

  task automatic test_basic();
    ext_stall = 1'b0;
    drive_group(2'b11, 32'h100, 32'h104);
`ifdef FETCH_QUEUE_BYPASS_EN
    #1;
    n_checks++;
    if (out_valid !== 2'b11 || out_pc[0] !== 32'h100 || out_pc[1] !== 32'h104) begin
      n_fail++;
      $display("[TB] FAIL basic_bypass: got v=%b pc0=%h pc1=%h expected v=11 pc0=100 pc1=104", out_valid, out_pc[0], out_pc[1]);
    end
    tick();
    idle();
`else
    tick();
    idle();
    n_checks++;
    if (out_valid !== 2'b11 || out_pc[0] !== 32'h100 || out_pc[1] !== 32'h104) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: got v=%b pc0=%h pc1=%h expected v=11 pc0=100 pc1=104", out_valid, out_pc[0], out_pc[1]);
    end
    tick();
`endif
    n_checks++;
    if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL basic_drain: got %b expected 00", out_valid); end
  endtask

  task automatic test_stall_fill();
    ext_stall = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_ready%0d: got %b expected 1", g, o_ready); end
      drive_group(2'b11, 32'h300 + 32'(8 * g), 32'h304 + 32'(8 * g));
      tick();
    end
    drive_group(2'b11, 32'h340, 32'h344);
    tick();
    idle();
    n_checks++;
    if (o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_full: got %b expected 0", o_ready); end
    n_checks++;
    if (out_valid !== 2'b11 || out_pc[0] !== 32'h300 || out_pc[1] !== 32'h304) begin
      n_fail++;
      $display("[TB] FAIL fill_hold: got v=%b pc0=%h pc1=%h expected v=11 pc0=300 pc1=304", out_valid, out_pc[0], out_pc[1]);
    end
    ext_stall = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL fill_drain: got %b expected 00", out_valid); end
  endtask

  task automatic test_compaction();
    ext_stall = 1'b1;
    drive_group(2'b10, 32'h0, 32'h204);
    tick();
    drive_group(2'b11, 32'h208, 32'h20C);
    tick();
    idle();
    n_checks++;
    if (out_valid !== 2'b11 || out_pc[0] !== 32'h204 || out_pc[1] !== 32'h208) begin
      n_fail++;
      $display("[TB] FAIL compact_first: got v=%b pc0=%h pc1=%h expected v=11 pc0=204 pc1=208", out_valid, out_pc[0], out_pc[1]);
    end
    ext_stall = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 2'b01 || out_pc[0] !== 32'h20C || out_pc[1] !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL compact_tail: got v=%b pc0=%h pc1=%h expected v=01 pc0=20c pc1=0", out_valid, out_pc[0], out_pc[1]);
    end
    tick();
    n_checks++;
    if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL compact_empty: got %b expected 00", out_valid); end
  endtask

  task automatic test_redirect();
    ext_stall = 1'b1;
    drive_group(2'b11, 32'h400, 32'h404);
    tick();
    drive_group(2'b11, 32'h408, 32'h40C);
    tick();
    drive_group(2'b10, 32'h0, 32'h410);
    tick();
    fb_redirect = 1'b1;
    drive_group(2'b11, 32'h500, 32'h504);
    tick();
    fb_redirect = 1'b0;
    idle();
    n_checks++;
    if (out_valid !== 2'b00 || o_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL redirect_clear: got v=%b ready=%b expected v=00 ready=1", out_valid, o_ready);
    end
    ext_stall = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL redirect_absent: got %b expected 00", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    int          pops_before;
    pc = 32'h1000;
    pops_before = pop_total;
    ext_stall = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive_group(2'b11, pc, pc + 32'h4);
      pc = pc + 32'h8;
      tick();
    end
    idle();
    tick();
    tick();
    n_checks++;
    if (pop_total - pops_before != 6 * DEPTH) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d entries retired expected %0d", pop_total - pops_before, 6 * DEPTH);
    end
    n_checks++;
    if (out_valid !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_empty: got v=%b pending=%0d expected v=00 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    ext_stall = 1'b1;
    for (int g = 0; g < 3; g++) begin
      drive_group(2'b11, 32'h600 + 32'(8 * g), 32'h604 + 32'(8 * g));
      tick();
    end
    reset = 1'b0;
    drive_group(2'b11, 32'h700, 32'h704);
    tick();
    reset = 1'b1;
    idle();
    n_checks++;
    if (o_ready !== 1'b1 || out_valid !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL midreset_clear: got ready=%b v=%b expected ready=1 v=00", o_ready, out_valid);
    end
    ext_stall = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL midreset_absent: got %b expected 00", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h8000;
    for (int i = 0; i < 300; i++) begin
      ext_stall = ($urandom_range(0, 2) == 0);
      ext_flush = ($urandom_range(0, 40) == 0);
      drive_group(2'($urandom_range(0, 3)), pc, pc + 32'h4);
      pc = pc + 32'h8;
      tick();
    end
    ext_flush = 1'b0;
    ext_stall = 1'b0;
    idle();
    repeat (6) tick();
    n_checks++;
    if (out_valid !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL random_drain: got v=%b pending=%0d expected v=00 pending=0", out_valid, exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    ext_flush = 1'b0;
    fb_redirect = 1'b0;
    ext_stall = 1'b0;
    idle();
    mon_en = 1;
    test_reset();
    test_basic();
    test_stall_fill();
    test_compaction();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, meaning: queue entries; power of two, minimum 4.
REQ-002 Parameter ADDR_W, default `ADDR_WIDTH, meaning: PC width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 ext_flush  in  1  pipeline flush from backend.
REQ-006 fb_redirect  in  1  decode-stage redirect (mispredict detected in decode).
REQ-007 ext_stall  in  1  decode not accepting this cycle.
REQ-008 in_valid  in  2  per-slot fetch valid; slot 0 is older.
REQ-009 in_instr  in  2x32  fetched instructions.
REQ-010 in_pc  in  2xADDR_W  instruction PCs.
REQ-011 in_guesses_branch  in  2  predictor hit flag per slot.
REQ-012 in_prediction  in  2  predicted direction per slot (1 = TAKEN).
REQ-013 o_ready  out  1  queue can accept a full 2-wide fetch group this cycle.
REQ-014 out_valid, out_instr, out_pc, out_guesses_branch, out_prediction  out  2-wide, same widths as inputs  two oldest entries presented to decode.

Function
REQ-015 Push: a group is accepted iff o_ready=1 and at least one in_valid bit is set; invalid slots are never written.
REQ-016 Compaction: in_valid=2'b10 writes slot 1 as a single entry; in_valid=2'b11 writes slot 0 then slot 1 in order.
REQ-017 o_ready=1 iff free entries (DEPTH - count) >= 2, computed from the registered count only (no same-cycle pop credit).
REQ-018 Output slot 0 shows the head entry and slot 1 shows head+1; out_valid[0]=(count>=1), out_valid[1]=(count>=2); out_valid[1] never 1 while out_valid[0]=0.
REQ-019 Pop: when ext_stall=0, all presented valid entries (0, 1 or 2) are consumed at the clock edge; when ext_stall=1, nothing is popped and outputs hold.
REQ-020 Simultaneous push and pop is permitted; next count = count + pushed - popped.
REQ-021 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits and saturates neither way (never exceeds DEPTH, never below 0 by construction).
REQ-022 Flush: ext_flush or fb_redirect clears head, tail and count in the next cycle; a same-cycle push is discarded; flush overrides stall.
REQ-023 Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle), bypass excepted (REQ-027).
REQ-024 Empty: out_valid=2'b00, out_* data fields are don't-care but driven zero.
REQ-025 Full (count >= DEPTH-1): o_ready=0, the fetch group is held upstream, no entry is overwritten.

Reset
REQ-026 On reset=0 at a clock edge: head=0, tail=0, count=0, o_ready=1, out_valid=2'b00, out data zero; storage contents need not be cleared; reset mid-operation discards all entries and any same-cycle push.

Configuration
REQ-027 Macro FETCH_QUEUE_BYPASS_EN: when defined, if count=0, ext_stall=0 and no flush, valid input slots drive out_* combinationally in the same cycle, are consumed by decode and not written to storage; partial bypass is not performed when count>0. When undefined, no combinational path from in_* to out_* exists and minimum latency is one cycle.

Verification
REQ-028 Reset then push {pc=0x100,0x104} both valid, ext_stall=0 -> next cycle out_valid=2'b11, out_pc={0x100,0x104}; with bypass, same cycle.
REQ-029 ext_stall=1, push four 2-wide groups with DEPTH=8 -> o_ready=1 for count 0..6, drops to 0 when count=8 after the 4th group; outputs hold the first group throughout.
REQ-030 Push in_valid=2'b10 pc=0x204, then 2'b11 {0x208,0x20C} under stall, release stall -> out_pc sequence 0x204,0x208 then 0x20C alone with out_valid=2'b01.
REQ-031 Count=5, assert fb_redirect with a simultaneous valid push -> next cycle count=0, out_valid=2'b00, pushed group absent.
REQ-032 Continuous push 2/cycle with ext_stall=0 for 3*DEPTH cycles -> pointers wrap, PCs emerge in strict program order, no loss, no duplication.
REQ-033 reset=0 asserted mid-stream with count=6 -> next cycle count=0, o_ready=1, out_valid=2'b00.
